fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Parametrised fetch stage: PC generation, synchronous-read instruction RAM, and a
//   prefetch queue feeding decode through a valid/ready handshake. Supports stall
//   (back-pressure from decode) and redirect (branch/jump/exception) with flush.
//   Sits between the PC source and the decode stage; the instruction RAM is internal.
// PARAMETERS
//   WIDTH      `WORD  datapath/PC width in bits
//   IMEM_POWER 18     log2 of instruction RAM depth in words
//   QDEPTH     4      prefetch queue entries; power of two, >= 2
//   RESET_PC   0      PC value loaded on reset
// PORTS
//   clk            in   1      clock
//   reset          in   1      reset, asynchronous, active-low
//   redirect_valid in   1      pulse: discard queued/in-flight fetches, restart at redirect_pc
//   redirect_pc    in   WIDTH  new PC; bits [1:0] ignored (treated as 0)
//   valid_d        out  1      queue head holds an instruction for decode
//   ready_d        in   1      decode accepts head this cycle
//   instr_d        out  WIDTH  head instruction word
//   pc_d           out  WIDTH  PC of head instruction
//   pcplus4_d      out  WIDTH  pc_d + 4 (modulo 2^WIDTH)
// BEHAVIOUR
//   Reset (reset==0, async): pc=RESET_PC, queue empty, in-flight flag clear;
//     valid_d=0, instr_d/pc_d=0, pcplus4_d=4. RAM contents untouched.
//   Issue: each cycle, if no redirect and (count + inflight) < QDEPTH: read RAM[pc[IMEM_POWER+1:2]],
//     latch req_pc=pc, set inflight, pc <= pc+4. Else no read, pc holds, inflight clears.
//   Index wraps modulo 2^IMEM_POWER; pc wraps modulo 2^WIDTH.
//   Response: the cycle after an issue, {req_pc, rdata} pushed into queue.
//   Pop: valid_d && ready_d removes head at clock edge. Push and pop same cycle: count unchanged.
//   Latency: first issue in first cycle after reset release (cycle 0); valid_d=1 in cycle 2.
//   Throughput: 1 instr/cycle sustained while ready_d=1.
//   Full: issue blocked so the in-flight response always has a slot; no entry ever dropped.
//   Stall: ready_d=0 holds head stable (valid_d, instr_d, pc_d unchanged) until accepted.
//   Redirect in cycle t (highest priority, beats push/pop/issue):
//     queue emptied, in-flight response discarded, pc <= {redirect_pc[WIDTH-1:2],2'b00};
//     no issue in t; valid_d=0 in t+1 and t+2; first redirected instr valid_d=1 in t+3.
//     A pop handshake in cycle t still counts as consumed by decode (decode's responsibility).
//   Back-to-back redirects: last one wins; each restarts the t+3 latency.
//   Reset asserted mid-operation: immediate return to reset state regardless of queue state.
//   RAM is write-free from RTL; loaded by testbench/backdoor (exposed verilator public).
// CONFIGURATION
//   FETCH_PERF_EN defined: adds outputs perf_fetched (32, instr popped), perf_stalls
//     (32, cycles valid_d && !ready_d), perf_redirects (32); cleared on reset, wrap at 2^32.
//   Not defined: those ports and counters absent; all other behaviour identical.
// STRUCTURE
//   cpu_pkg: WORD, fetch_entry_t {pc, instr}, RESET_PC default, PC increment constant.
//   Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, params QDEPTH,
//     ports push/pop/flush/count/head; flush has priority over push and pop.
//   fetch_unit: PC register, issue/credit logic, RAM, in-flight tracking, perf counters.
// TESTING
//   Reset, RAM[i]=0x100+i, ready_d=1 -> cycle2 valid_d=1 pc_d=0 instr_d=0x100; then pc 4,8,12 each cycle.
//   ready_d=0 from cycle 2 for 10 cycles -> head stays pc_d=0; at most QDEPTH entries; on release pcs 0,4,8,.. no gaps/dups.
//   Redirect to 0x40 at t with full queue -> valid_d=0 t+1,t+2; t+3 pc_d=0x40 instr_d=0x110.
//   Redirect 0x43 then 0x80 next cycle -> first valid pc_d=0x80, nothing from 0x40 appears.
//   IMEM_POWER=4, pc runs to 0x3C -> next fetch pc_d=0x40, instr_d=RAM[0] (index wrap).
//   Async reset low mid-stream -> valid_d=0 same cycle without clock; restarts at RESET_PC.
//   With FETCH_PERF_EN: 5 pops, 3 stall cycles, 1 redirect -> counters 5/3/1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch_queue and fetch_unit.
package cpu_pkg;

  localparam int WORD = 32;
  localparam int PC_INC = 4;
  localparam logic [WORD-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between instruction RAM and decode.
// Flush beats push and pop; a push into a full queue is refused.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int  QDEPTH  = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int  CW      = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output entry_t        head
);

  localparam int PW = $clog2(QDEPTH);

  entry_t mem_q [QDEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != CW'(QDEPTH)) || pop_ok);
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (pop_ok)
        rd_d = rd_q + PW'(1);
      if (push_ok)
        wr_d = wr_q + PW'(1);
      count_d = count_q + CW'(push_ok)
              - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem_q[wr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, credit-based issue, sync-read imem, prefetch queue.
// Define FETCH_PERF_EN to add perf_fetched/perf_stalls/perf_redirects counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              WIDTH      = WORD,
  parameter int              IMEM_POWER = 18,
  parameter int              QDEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             valid_d,
  input  logic             ready_d,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pcplus4_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stalls,
  output logic [31:0]      perf_redirects
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  // Loaded by backdoor only; never written here.
  logic [WIDTH-1:0] imem [2**IMEM_POWER];

  logic [WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]      req_pc_q, req_pc_d;
  logic                  infl_q, infl_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [IMEM_POWER-1:0] idx;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  issue;
  logic                  pop;
  entry_t                head;
  entry_t                resp;
  logic                  unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign idx = fetch_pc_q[IMEM_POWER+1:2];

  // Credit: queued plus in-flight must leave room for the response.
  assign occ   = {1'b0, count} + (CW+1)'(infl_q);
  assign issue = !redirect_valid
              && (occ < (CW+1)'(QDEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    infl_d     = 1'b0;
    rdata_d    = rdata_q;
    unique case (1'b1)
      redirect_valid: begin
        fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      end
      issue: begin
        fetch_pc_d = fetch_pc_q + WIDTH'(PC_INC);
        req_pc_d   = fetch_pc_q;
        infl_d     = 1'b1;
        rdata_d    = imem[idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      infl_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      infl_q     <= infl_d;
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign resp.pc    = req_pc_q;
  assign resp.instr = rdata_q;
  assign pop        = valid_d && ready_d;

  fetch_queue #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (infl_q),
    .push_data (resp),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign valid_d   = (count != '0);
  assign pc_d      = valid_d ? head.pc : '0;
  assign instr_d   = valid_d ? head.instr : '0;
  assign pcplus4_d = pc_d + WIDTH'(PC_INC);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q
                     + 32'(valid_d && ready_d);
    perf_stalls_d    = perf_stalls_q
                     + 32'(valid_d && !ready_d);
    perf_redirects_d = perf_redirects_q
                     + 32'(redirect_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q   <= '0;
      perf_stalls_q    <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_stalls_q    <= perf_stalls_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_stalls    = perf_stalls_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: default imem plus a 16-word imem instance for index wrap.
// Expected stream comes from a queue-level model of issue/response/pop rules.
module tb_fetch_unit;

  localparam int QD = 4;
  localparam int PW_A = 18;
  localparam int PW_B = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready_d = 1'b1;

  logic        valid_a, valid_b;
  logic [31:0] instr_a, pc_a, p4_a;
  logic [31:0] instr_b, pc_b, p4_b;
`ifdef FETCH_PERF_EN
  logic [31:0] pf_a, ps_a, pr_a;
  logic [31:0] pf_b, ps_b, pr_b;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          infl;
  logic [31:0] ipc;
  logic [31:0] npc;
  int unsigned m_pf, m_ps, m_pr;

  always #5 clk = ~clk;

  fetch_unit #(.IMEM_POWER(PW_A), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .valid_d(valid_a), .ready_d(ready_d),
    .instr_d(instr_a), .pc_d(pc_a),
    .pcplus4_d(p4_a)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_a), .perf_stalls(ps_a),
    .perf_redirects(pr_a)
`endif
  );

  fetch_unit #(.IMEM_POWER(PW_B), .QDEPTH(QD)) dut_w (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .valid_d(valid_b), .ready_d(ready_d),
    .instr_d(instr_b), .pc_d(pc_b),
    .pcplus4_d(p4_b)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_b), .perf_stalls(ps_b),
    .perf_redirects(pr_b)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_instr(
    input logic [31:0] pc, input int pw);
    return 32'h100 + ((pc >> 2) & ((32'd1 << pw) - 32'd1));
  endfunction

  task automatic model_reset();
    mq.delete();
    infl = 0;
    ipc = '0;
    npc = '0;
    m_pf = 0;
    m_ps = 0;
    m_pr = 0;
  endtask

  // One clock edge of the fetch stage, described as queue operations.
  task automatic model_edge();
    int occ;
    bit has;
    has = (mq.size() != 0);
    if (has && ready_d) m_pf++;
    if (has && !ready_d) m_ps++;
    if (redirect_valid) begin
      m_pr++;
      mq.delete();
      infl = 0;
      npc = redirect_pc & ~32'h3;
    end else begin
      occ = mq.size() + (infl ? 1 : 0);
      if (has && ready_d) void'(mq.pop_front());
      if (infl) mq.push_back(ipc);
      if (occ < QD) begin
        infl = 1;
        ipc = npc;
        npc = npc + 32'd4;
      end else begin
        infl = 0;
      end
    end
  endtask

  task automatic compare();
    logic v;
    v = (mq.size() != 0);
    chk("valid_a", {31'd0, valid_a}, {31'd0, v});
    chk("valid_b", {31'd0, valid_b}, {31'd0, v});
    if (v) begin
      chk("pc_a", pc_a, mq[0]);
      chk("instr_a", instr_a, exp_instr(mq[0], PW_A));
      chk("pc4_a", p4_a, mq[0] + 32'd4);
      chk("pc_b", pc_b, mq[0]);
      chk("instr_b", instr_b, exp_instr(mq[0], PW_B));
      chk("pc4_b", p4_b, mq[0] + 32'd4);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_pc", pc_a, 32'd0);
    chk("rst_instr", instr_a, 32'd0);
    chk("rst_pc4", p4_a, 32'd4);
    model_reset();
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] first_pc;
    bit seen_wrap;
    bit got;
    model_reset();
    for (int i = 0; i < 4096; i++)
      dut.imem[i] = 32'h100 + i;
    for (int i = 0; i < 16; i++)
      dut_w.imem[i] = 32'h100 + i;

    #2;
    chk("por_valid", {31'd0, valid_a}, 32'd0);
    chk("por_pc4", p4_a, 32'd4);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Streaming with ready high, including the small-imem wrap.
    seen_wrap = 0;
    for (int i = 0; i < 26; i++) begin
      sample();
      if (i == 2) begin
        chk("first_pc", pc_a, 32'd0);
        chk("first_instr", instr_a, 32'h100);
      end
      if (i == 3) chk("second_pc", pc_a, 32'd4);
      if (valid_b && pc_b == 32'h40) begin
        seen_wrap = 1;
        chk("wrap_instr", instr_b, 32'h100);
      end
      advance();
    end
    chk("wrap_seen", {31'd0, seen_wrap}, 32'd1);

    // Stall from cycle 2 for 10 cycles, then release.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ready_d = (i < 2);
      sample();
      if (i >= 2) chk("stall_head", pc_a, 32'd0);
      advance();
    end
    ready_d = 1'b1;
    for (int i = 0; i < 12; i++) cyc();

    // Redirect with a full queue.
    ready_d = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    ready_d = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sample();
      if (k < 3) begin
        chk("redir_gap", {31'd0, valid_a}, 32'd0);
      end else begin
        chk("redir_valid", {31'd0, valid_a}, 32'd1);
        chk("redir_pc", pc_a, 32'h40);
        chk("redir_instr", instr_a, 32'h110);
      end
      advance();
    end
    for (int i = 0; i < 5; i++) cyc();

    // Back-to-back redirects: the later one wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    cyc();
    redirect_pc = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    got = 0;
    first_pc = '0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (valid_a && !got) begin
        got = 1;
        first_pc = pc_a;
      end
      advance();
    end
    chk("b2b_first", first_pc, 32'h80);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 4; i++) cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid_a", {31'd0, valid_a}, 32'd0);
    chk("async_valid_b", {31'd0, valid_b}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (i == 2) chk("restart_pc", pc_a, 32'd0);
      advance();
    end

    // Randomized ready and redirects.
    for (int i = 0; i < 400; i++) begin
      ready_d = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom_range(0, 32'h7FF);
      cyc();
    end
    redirect_valid = 1'b0;
    ready_d = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

`ifdef FETCH_PERF_EN
    // 5 pops, 3 stall cycles, 1 redirect.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ready_d = (i < 7);
      redirect_valid = (i == 9);
      redirect_pc = 32'h20;
      cyc();
    end
    redirect_valid = 1'b0;
    sample();
    chk("perf_fetched", pf_a, 32'd5);
    chk("perf_stalls", ps_a, 32'd3);
    chk("perf_redirects", pr_a, 32'd1);
    chk("perf_fetched_m", pf_b, m_pf);
    chk("perf_stalls_m", ps_b, m_ps);
    chk("perf_redirects_m", pr_b, m_pr);
    advance();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
